// File: rtl/vga_timing_pkg.sv
// Shared constants, types and helpers for the VGA pixel-timing generator.
// Defaults describe 640x480 at 60 Hz with one pixel per enabled clock.
package vga_timing_pkg;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;

  localparam int DEF_H_TOTAL =
    DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL =
    DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int DEF_HS_START = DEF_H_VISIBLE + DEF_H_FP;
  localparam int DEF_HS_END   = DEF_HS_START + DEF_H_SYNC - 1;
  localparam int DEF_VS_START = DEF_V_VISIBLE + DEF_V_FP;
  localparam int DEF_VS_END   = DEF_VS_START + DEF_V_SYNC - 1;

  typedef logic [9:0]  coord_t;
  typedef logic [10:0] wide_t;

  function automatic logic in_range(
    input wide_t val,
    input wide_t lo,
    input wide_t hi
  );
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register with synchronous reset.
// DEPTH of zero degenerates to a combinational pass-through.
module vga_delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_pass
    logic unused_ctl;
    assign unused_ctl = ^{clk, reset, en};
    assign q = d;
  end else begin : g_shift
    logic [WIDTH-1:0] stg [DEPTH];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < DEPTH; i++) stg[i] <= RESET_VAL;
      end else if (en) begin
        stg[0] <= d;
        for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
      end
    end

    assign q = stg[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Pixel-timing generator: scan counters, blank and sync aligned to the
// downstream mapper latency, and one-cycle line/frame start pulses.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_VISIBLE   = DEF_H_VISIBLE,
  parameter int   H_FP        = DEF_H_FP,
  parameter int   H_SYNC      = DEF_H_SYNC,
  parameter int   H_BP        = DEF_H_BP,
  parameter int   V_VISIBLE   = DEF_V_VISIBLE,
  parameter int   V_FP        = DEF_V_FP,
  parameter int   V_SYNC      = DEF_V_SYNC,
  parameter int   V_BP        = DEF_V_BP,
  parameter logic SYNC_ACTIVE = 1'b0,
  parameter int   BLANK_DELAY = 1,
  parameter int   SYNC_DELAY  = 2
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       pix_en,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam wide_t HS_START = wide_t'(H_VISIBLE + H_FP);
  localparam wide_t HS_END   = wide_t'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam wide_t VS_START = wide_t'(V_VISIBLE + V_FP);
  localparam wide_t VS_END   = wide_t'(V_VISIBLE + V_FP + V_SYNC - 1);

  localparam coord_t X_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t Y_LAST = coord_t'(V_TOTAL - 1);

  localparam logic [1:0] SYNC_IDLE = {2{~SYNC_ACTIVE}};

  if (H_TOTAL > 1024 || V_TOTAL > 1024 ||
      H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_cfg
    $error("vga_timing_gen: illegal timing parameters");
  end

  coord_t x_q, y_q;
  logic   ls_q, fs_q;

  // Pulses are cleared on every edge so they stay one vga_clk wide
  // even when pix_en is toggling.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      x_q  <= '0;
      y_q  <= '0;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      ls_q <= 1'b0;
      fs_q <= 1'b0;
      if (pix_en) begin
        if (x_q == X_LAST) begin
          x_q  <= '0;
          ls_q <= 1'b1;
          if (y_q == Y_LAST) begin
            y_q  <= '0;
            fs_q <= 1'b1;
          end else begin
            y_q <= y_q + 10'd1;
          end
        end else begin
          x_q <= x_q + 10'd1;
        end
      end
    end
  end

  wide_t x_w, y_w;
  logic  vis_raw, hs_raw, vs_raw;
  logic  hs_lvl, vs_lvl;

  assign x_w     = {1'b0, x_q};
  assign y_w     = {1'b0, y_q};
  assign vis_raw = (x_w < wide_t'(H_VISIBLE)) &&
                   (y_w < wide_t'(V_VISIBLE));
  assign hs_raw  = in_range(x_w, HS_START, HS_END);
  assign vs_raw  = in_range(y_w, VS_START, VS_END);
  assign hs_lvl  = hs_raw ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign vs_lvl  = vs_raw ? SYNC_ACTIVE : ~SYNC_ACTIVE;

  vga_delay_line #(
    .WIDTH    (1),
    .DEPTH    (BLANK_DELAY),
    .RESET_VAL(1'b0)
  ) u_blank_dly (
    .clk  (vga_clk),
    .reset(reset),
    .en   (pix_en),
    .d    (vis_raw),
    .q    (blank)
  );

  vga_delay_line #(
    .WIDTH    (2),
    .DEPTH    (SYNC_DELAY),
    .RESET_VAL(SYNC_IDLE)
  ) u_sync_dly (
    .clk  (vga_clk),
    .reset(reset),
    .en   (pix_en),
    .d    ({hs_lvl, vs_lvl}),
    .q    ({hs, vs})
  );

  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a reduced raster so that
// whole frames fit in a short run; reference derived from pixel index.
module tb_vga_timing_gen;

  localparam int HV = 16, HF = 3, HS = 5, HB = 4;
  localparam int VV = 10, VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FR = HT * VT;

  logic       vga_clk = 1'b0;
  logic       reset   = 1'b1;
  logic       pix_en  = 1'b0;
  logic [9:0] DrawX, DrawY;
  logic       blank, hs, vs, line_start, frame_start;

  int n;
  bit en_edge;
  int passed;
  int total;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_ACTIVE(1'b0), .BLANK_DELAY(1), .SYNC_DELAY(2)
  ) dut (
    .vga_clk    (vga_clk),
    .reset      (reset),
    .pix_en     (pix_en),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .blank      (blank),
    .hs         (hs),
    .vs         (vs),
    .line_start (line_start),
    .frame_start(frame_start)
  );

  always #5 vga_clk = ~vga_clk;

  function automatic bit vis(int k);
    return ((k % HT) < HV) && (((k / HT) % VT) < VV);
  endfunction

  function automatic bit hsy(int k);
    int x = k % HT;
    return (x >= HV + HF) && (x <= HV + HF + HS - 1);
  endfunction

  function automatic bit vsy(int k);
    int y = (k / HT) % VT;
    return (y >= VV + VF) && (y <= VV + VF + VS - 1);
  endfunction

  // k = enabled pixel steps since reset; e = last edge advanced pixels
  function automatic logic [24:0] exp_vec(int k, bit e);
    int x = k % HT;
    int y = (k / HT) % VT;
    bit b  = (k >= 1) && vis(k - 1);
    bit h  = !((k >= 2) && hsy(k - 2));
    bit v  = !((k >= 2) && vsy(k - 2));
    bit ls = e && (k > 0) && (x == 0);
    bit fs = ls && (y == 0);
    return {10'(x), 10'(y), b, h, v, ls, fs};
  endfunction

  function automatic logic [24:0] act_vec();
    return {DrawX, DrawY, blank, hs, vs, line_start, frame_start};
  endfunction

  task automatic step(input logic rst, input logic en);
    reset  = rst;
    pix_en = en;
    @(posedge vga_clk);
    #1;
    if (rst) begin
      n = 0;
      en_edge = 0;
    end else if (en) begin
      n++;
      en_edge = 1;
    end else begin
      en_edge = 0;
    end
  endtask

  task automatic test_reset();
    logic [24:0] idle;
    idle = {20'd0, 1'b0, 1'b1, 1'b1, 2'b00};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'(i % 2));
      total++;
      if (act_vec() !== idle)
        $display("FAIL reset cyc%0d got=%h want=%h", i, act_vec(), idle);
      else passed++;
    end
  endtask

  task automatic test_first_line();
    int ls_cnt = 0;
    int ls_at  = -1;
    logic [9:0] y_at = '0;
    for (int i = 1; i <= HT + 1; i++) begin
      step(1'b0, 1'b1);
      total++;
      if (act_vec() !== exp_vec(n, en_edge))
        $display("FAIL first_line n=%0d got=%h want=%h",
                 n, act_vec(), exp_vec(n, en_edge));
      else passed++;
      if (line_start) begin
        ls_cnt++;
        ls_at = i;
        y_at  = DrawY;
      end
    end
    total++;
    if (ls_cnt !== 1 || ls_at !== HT || y_at !== 10'd1)
      $display("FAIL line_pulse got cnt=%0d at=%0d y=%0d want 1/%0d/1",
               ls_cnt, ls_at, y_at, HT);
    else passed++;
  endtask

  task automatic test_frame();
    int fs_cnt = 0, vs_cnt = 0, hs_cnt = 0;
    step(1'b1, 1'b0);
    for (int i = 0; i < 2 * FR; i++) begin
      step(1'b0, 1'b1);
      total++;
      if (act_vec() !== exp_vec(n, en_edge))
        $display("FAIL frame n=%0d got=%h want=%h",
                 n, act_vec(), exp_vec(n, en_edge));
      else passed++;
      if (frame_start) fs_cnt++;
      if (!vs) vs_cnt++;
      if (!hs) hs_cnt++;
    end
    total++;
    if (fs_cnt !== 2)
      $display("FAIL frame_pulses got=%0d want=2", fs_cnt);
    else passed++;
    total++;
    if (vs_cnt !== 2 * VS * HT)
      $display("FAIL vs_width got=%0d want=%0d", vs_cnt, 2 * VS * HT);
    else passed++;
    total++;
    if (hs_cnt !== 2 * VT * HS)
      $display("FAIL hs_width got=%0d want=%0d", hs_cnt, 2 * VT * HS);
    else passed++;
  endtask

  task automatic test_random_en();
    for (int i = 0; i < 1500; i++) begin
      step(1'b0, 1'($urandom % 2));
      total++;
      if (act_vec() !== exp_vec(n, en_edge))
        $display("FAIL random_en n=%0d got=%h want=%h",
                 n, act_vec(), exp_vec(n, en_edge));
      else passed++;
    end
  endtask

  task automatic test_alternate();
    int fs_at [$];
    int ls_w = 0;
    step(1'b1, 1'b0);
    for (int i = 0; i < 4 * FR + 6; i++) begin
      step(1'b0, 1'(i % 2 == 0));
      total++;
      if (act_vec() !== exp_vec(n, en_edge))
        $display("FAIL alternate n=%0d got=%h want=%h",
                 n, act_vec(), exp_vec(n, en_edge));
      else passed++;
      if (frame_start) fs_at.push_back(i);
      if (line_start && !pix_en) ls_w++;
    end
    total++;
    if (fs_at.size() !== 2)
      $display("FAIL alt_frames got=%0d want=2", fs_at.size());
    else if (fs_at[1] - fs_at[0] !== 2 * FR)
      $display("FAIL alt_period got=%0d want=%0d",
               fs_at[1] - fs_at[0], 2 * FR);
    else passed++;
    total++;
    if (ls_w !== 0)
      $display("FAIL alt_pulse_width got=%0d want=0", ls_w);
    else passed++;
  endtask

  task automatic test_mid_reset();
    logic [24:0] idle;
    int tgt;
    idle = {20'd0, 1'b0, 1'b1, 1'b1, 2'b00};
    tgt  = 5 * HT + 7;
    step(1'b1, 1'b0);
    for (int i = 0; i < tgt; i++) step(1'b0, 1'b1);
    total++;
    if (DrawX !== 10'd7 || DrawY !== 10'd5 || blank !== 1'b1)
      $display("FAIL pre_reset got x=%0d y=%0d b=%b want 7 5 1",
               DrawX, DrawY, blank);
    else passed++;
    step(1'b1, 1'b1);
    total++;
    if (act_vec() !== idle)
      $display("FAIL mid_reset got=%h want=%h", act_vec(), idle);
    else passed++;
    for (int i = 0; i < 3 * HT; i++) begin
      step(1'b0, 1'b1);
      total++;
      if (act_vec() !== exp_vec(n, en_edge))
        $display("FAIL post_reset n=%0d got=%h want=%h",
                 n, act_vec(), exp_vec(n, en_edge));
      else passed++;
    end
  endtask

  initial begin
    n = 0;
    en_edge = 0;
    passed = 0;
    total = 0;
    test_reset();
    test_first_line();
    test_frame();
    test_random_en();
    test_alternate();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
